// File: rtl/reduce_gate_pipe.sv
// Pipelined N-input AND/OR/XOR reduction (with inverted variants) behind valid/ready.
// One registered tree level per stage; the whole pipe stalls together when the output is held.
module reduce_gate_pipe #(
   parameter int N_IN  = 3,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_IN-1:0]  in_data,
   input  logic [2:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_z,
   output logic             out_err,
   output logic [CNT_W-1:0] res_cnt
);

   localparam int LAT    = (N_IN > 2) ? $clog2(N_IN) : 1;
   localparam int LEAVES = 1 << LAT;

   logic              advance;
   logic              pad;
   logic [LEAVES-1:0] leaves;
   logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;

   function automatic logic base_op(input logic [2:0] m, input logic a, input logic b);
      case (m)
         3'b000, 3'b011: base_op = a & b;
         3'b001, 3'b100: base_op = a | b;
         default:        base_op = a ^ b;
      endcase
   endfunction

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // Unused leaves carry the identity of the base op so they never change the result.
   always_comb begin
      pad               = (in_mode == 3'b000) || (in_mode == 3'b011);
      leaves            = {LEAVES{pad}};
      leaves[N_IN-1:0]  = in_data;
   end

   for (genvar k = 0; k < LAT; k++) begin : g_lvl
      localparam int WI = LEAVES >> k;
      localparam int WO = WI / 2;

      logic [WI-1:0] src;
      logic [2:0]    src_mode;
      logic          src_valid;
      logic [WO-1:0] red;
      logic [WO-1:0] d_d;
      logic [WO-1:0] d_q;
      logic [2:0]    mode_q;
      logic          valid_q;

      if (k == 0) begin : g_src
         assign src       = leaves;
         assign src_mode  = in_mode;
         assign src_valid = in_valid && advance;
      end else begin : g_src
         assign src       = g_lvl[k-1].d_q;
         assign src_mode  = g_lvl[k-1].mode_q;
         assign src_valid = g_lvl[k-1].valid_q;
      end

      always_comb begin
         red = '0;
         for (int i = 0; i < WO; i++) begin
            red[i] = base_op(src_mode, src[2*i], src[2*i+1]);
         end
      end

      // Inversion and reserved-mode squashing happen only on the last level.
      always_comb begin
         d_d = red;
         if (k == LAT - 1) begin
            if (src_mode[2:1] == 2'b11) begin
               d_d = '0;
            end else if ((src_mode == 3'b011) || (src_mode == 3'b100) || (src_mode == 3'b101)) begin
               d_d = ~red;
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            d_q     <= '0;
            mode_q  <= '0;
         end else if (advance) begin
            valid_q <= src_valid;
            if (src_valid) begin
               d_q    <= d_d;
               mode_q <= src_mode;
            end
         end
      end
   end

   assign out_valid = g_lvl[LAT-1].valid_q;
   assign out_z     = g_lvl[LAT-1].d_q[0];
   assign out_err   = (g_lvl[LAT-1].mode_q[2:1] == 2'b11);

   always_comb begin
      res_cnt_d = res_cnt_q;
      if (out_valid && out_ready) begin
         res_cnt_d = res_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_cnt_q <= '0;
      end else begin
         res_cnt_q <= res_cnt_d;
      end
   end

   assign res_cnt = res_cnt_q;

endmodule

// File: tb/tb_reduce_gate_pipe.sv
// Random and directed stimulus for reduce_gate_pipe (N_IN=3 and N_IN=5/CNT_W=2 instances),
// compared against a slot-level reference model that reduces by counting ones.
module tb_reduce_gate_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [4:0]  in_data;
   logic [2:0]  in_mode;
   logic        out_ready;
   logic        cur;

   logic        iv3, ir3, ov3, oz3, oe3;
   logic [15:0] cnt3;
   logic        iv5, ir5, ov5, oz5, oe5;
   logic [1:0]  cnt5;

   logic        o_ready, o_valid, o_z, o_err;
   logic [31:0] o_cnt;

   int          errs   = 0;
   int          checks = 0;

   logic        mv [0:3];
   logic        mz [0:3];
   logic        me [0:3];
   int          lat, nin, cntw, mcnt;

   always #5 clk = ~clk;

   assign iv3 = in_valid && !cur;
   assign iv5 = in_valid && cur;

   reduce_gate_pipe #(.N_IN(3), .CNT_W(16)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .in_data(in_data[2:0]),
      .in_mode(in_mode), .out_valid(ov3), .out_ready(out_ready), .out_z(oz3),
      .out_err(oe3), .res_cnt(cnt3));

   reduce_gate_pipe #(.N_IN(5), .CNT_W(2)) dut5 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv5), .in_ready(ir5), .in_data(in_data),
      .in_mode(in_mode), .out_valid(ov5), .out_ready(out_ready), .out_z(oz5),
      .out_err(oe5), .res_cnt(cnt5));

   assign o_ready = cur ? ir5 : ir3;
   assign o_valid = cur ? ov5 : ov3;
   assign o_z     = cur ? oz5 : oz3;
   assign o_err   = cur ? oe5 : oe3;
   assign o_cnt   = cur ? {30'd0, cnt5} : {16'd0, cnt3};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Returns {err, z} from the count of ones among the n live inputs.
   function automatic logic [1:0] ref_reduce(input logic [4:0] d, input int n, input logic [2:0] m);
      int ones = 0;
      for (int i = 0; i < n; i++) ones += int'(d[i]);
      case (m)
         3'd0:    return {1'b0, ones == n};
         3'd1:    return {1'b0, ones != 0};
         3'd2:    return {1'b0, (ones % 2) == 1};
         3'd3:    return {1'b0, ones != n};
         3'd4:    return {1'b0, ones == 0};
         3'd5:    return {1'b0, (ones % 2) == 0};
         default: return 2'b10;
      endcase
   endfunction

   task automatic model_clear();
      for (int s = 0; s < 4; s++) begin
         mv[s] = 1'b0; mz[s] = 1'b0; me[s] = 1'b0;
      end
      mcnt = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      model_clear();
      #3;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // spot >= 0 additionally requires a valid output with {err,z} == spot[1:0].
   task automatic cycle(input logic iv, input logic [4:0] d, input logic [2:0] m,
                        input logic ordy, input int spot, output logic acc);
      logic       adv;
      logic [1:0] r;
      @(negedge clk);
      in_valid  = iv;
      in_data   = d;
      in_mode   = m;
      out_ready = ordy;
      #1;
      chk("out_valid", o_valid, mv[lat-1]);
      if (mv[lat-1]) begin
         chk("out_z", o_z, mz[lat-1]);
         chk("out_err", o_err, me[lat-1]);
      end
      chk("res_cnt", o_cnt, mcnt);
      adv = !mv[lat-1] || ordy;
      chk("in_ready", o_ready, adv);
      if (spot >= 0) begin
         chk("spot_valid", o_valid, 1);
         chk("spot_z", o_z, spot[0]);
         chk("spot_err", o_err, spot[1]);
      end
      acc = iv && adv;
      if (adv) begin
         if (mv[lat-1] && ordy) mcnt = (mcnt + 1) % (1 << cntw);
         for (int s = 3; s > 0; s--) begin
            mv[s] = mv[s-1]; mz[s] = mz[s-1]; me[s] = me[s-1];
         end
         r     = ref_reduce(d, nin, m);
         mv[0] = iv;
         mz[0] = r[0];
         me[0] = r[1];
      end
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 3'd0, 1'b1, -1, acc);
   endtask

   task automatic random_run(input int n);
      logic       acc, pend, rv, ordy;
      logic [4:0] rd;
      logic [2:0] rm;
      pend = 1'b0;
      rv = 1'b0; rd = '0; rm = '0;
      for (int c = 0; c < n; c++) begin
         if (!pend) begin
            rv = 1'($urandom_range(0, 1));
            rd = 5'($urandom);
            rm = 3'($urandom_range(0, 7));
         end
         ordy = ($urandom_range(0, 3) != 0);
         cycle(rv, rd, rm, ordy, -1, acc);
         pend = rv && !acc;
      end
      idle(lat + 2);
   endtask

   initial begin
      logic acc;
      cur = 1'b0; lat = 2; nin = 3; cntw = 16;
      model_clear();
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b1;
      #12 rst_n = 1'b1;
      #1;
      chk("rst_valid", ov3, 0);
      chk("rst_ready", ir3, 1);
      chk("rst_z", oz3, 0);
      chk("rst_err", oe3, 0);
      chk("rst_cnt", cnt3, 0);
      chk("rst_ready5", ir5, 1);

      for (int m = 0; m < 6; m++)
         for (int d = 0; d < 8; d++) cycle(1'b1, 5'(d), 3'(m), 1'b1, -1, acc);
      idle(3);

      // spot checks: 111 AND, 011 AND, 000 NOR, 101 XOR, 111 XNOR
      cycle(1'b1, 5'b111, 3'd0, 1'b1, -1, acc); cycle(1'b0, 0, 0, 1'b1, -1, acc); cycle(1'b0, 0, 0, 1'b1, 1, acc);
      cycle(1'b1, 5'b011, 3'd0, 1'b1, -1, acc); cycle(1'b0, 0, 0, 1'b1, -1, acc); cycle(1'b0, 0, 0, 1'b1, 0, acc);
      cycle(1'b1, 5'b000, 3'd4, 1'b1, -1, acc); cycle(1'b0, 0, 0, 1'b1, -1, acc); cycle(1'b0, 0, 0, 1'b1, 1, acc);
      cycle(1'b1, 5'b101, 3'd2, 1'b1, -1, acc); cycle(1'b0, 0, 0, 1'b1, -1, acc); cycle(1'b0, 0, 0, 1'b1, 0, acc);
      cycle(1'b1, 5'b111, 3'd5, 1'b1, -1, acc); cycle(1'b0, 0, 0, 1'b1, -1, acc); cycle(1'b0, 0, 0, 1'b1, 0, acc);

      // backpressure
      do_reset();
      cycle(1'b1, 5'b111, 3'd0, 1'b1, -1, acc);
      cycle(1'b1, 5'b001, 3'd1, 1'b0, -1, acc);
      for (int i = 0; i < 3; i++) cycle(1'b1, 5'b110, 3'd2, 1'b0, 1, acc);
      chk("bp_stall_ready", ir3, 0);
      cycle(1'b1, 5'b110, 3'd2, 1'b1, 1, acc);
      chk("bp_third_accepted", acc, 1);
      idle(4);
      chk("bp_cnt", cnt3, 3);

      // mode switch
      do_reset();
      cycle(1'b1, 5'b111, 3'd0, 1'b1, -1, acc);
      cycle(1'b1, 5'b111, 3'd3, 1'b1, -1, acc);
      cycle(1'b0, 0, 0, 1'b1, 1, acc);
      cycle(1'b0, 0, 0, 1'b1, 0, acc);

      // reserved mode then a valid one
      do_reset();
      cycle(1'b1, 5'b101, 3'd6, 1'b1, -1, acc);
      cycle(1'b1, 5'b101, 3'd0, 1'b1, -1, acc);
      cycle(1'b0, 0, 0, 1'b1, 2, acc);
      cycle(1'b0, 0, 0, 1'b1, 0, acc);
      idle(1);
      chk("rsv_cnt", cnt3, 2);

      // reset mid-flight
      do_reset();
      cycle(1'b1, 5'b111, 3'd0, 1'b1, -1, acc);
      cycle(1'b1, 5'b011, 3'd1, 1'b1, -1, acc);
      @(posedge clk);
      #2;
      chk("flight_valid_before", ov3, 1);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("flight_valid_async", ov3, 0);
      #4 rst_n = 1'b1;
      model_clear();
      #1;
      chk("flight_ready", ir3, 1);
      chk("flight_cnt", cnt3, 0);
      idle(4);

      random_run(300);

      // N_IN=5, CNT_W=2
      cur = 1'b1; lat = 3; nin = 5; cntw = 2;
      do_reset();
      cycle(1'b1, 5'b11111, 3'd0, 1'b1, -1, acc); idle(2); cycle(1'b0, 0, 0, 1'b1, 1, acc);
      cycle(1'b1, 5'b10000, 3'd1, 1'b1, -1, acc); idle(2); cycle(1'b0, 0, 0, 1'b1, 1, acc);
      cycle(1'b1, 5'b01111, 3'd0, 1'b1, -1, acc);
      cycle(1'b1, 5'b00000, 3'd4, 1'b1, -1, acc);
      cycle(1'b1, 5'b10101, 3'd2, 1'b1, -1, acc);
      idle(4);
      chk("wrap_cnt", cnt5, 1);

      random_run(200);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
